// File: rtl/uflash_arb.sv
// Round-robin arbiter + page write-protect gate for the user flash; accepted access: f_sel 1 cycle after grant, ready 1 cycle after f_ready.
// Rejected access answers 1 cycle after grant with no flash cycle; requesters hold sel until their ready pulse.
module uflash_arb #(
  parameter logic [37:0] WP_PAGES = 38'h0,
  parameter logic        RR_INIT  = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_sel,
  input  logic [3:0]  m0_wstrb,
  input  logic [14:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_sel,
  input  logic [3:0]  m1_wstrb,
  input  logic [14:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        f_sel,
  output logic [3:0]  f_wstrb,
  output logic [14:0] f_addr,
  output logic [31:0] f_wdata,
  input  logic        f_ready,
  input  logic [31:0] f_rdata,
  output logic        err,
  output logic        err_src,
  output logic [5:0]  err_page,
  input  logic        err_clr,
  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

  state_t      state, state_nxt;
  logic        ptr;
  logic        own;
  logic [3:0]  req_wstrb;
  logic [14:0] req_addr;
  logic [31:0] req_wdata;

  logic        win;
  logic [3:0]  c_wstrb;
  logic [14:0] c_addr;
  logic [31:0] c_wdata;
  logic [5:0]  c_page;
  logic        c_wr;
  logic        c_ill;
  logic        c_wp;
  logic        reject;
  logic        grant;

  // Candidate request as seen on the grant edge; pages above 37 do not exist and are treated as protected.
  always_comb begin
    win     = (m0_sel && m1_sel) ? ptr : m1_sel;
    c_wstrb = win ? m1_wstrb : m0_wstrb;
    c_addr  = win ? m1_addr  : m0_addr;
    c_wdata = win ? m1_wdata : m0_wdata;
    c_page  = c_addr[14:9];
    c_wr    = (c_wstrb == 4'h1) || (c_wstrb == 4'hF);
    c_ill   = !c_wr && (c_wstrb != 4'h0);
    c_wp    = (c_page > 6'd37) ? 1'b1 : WP_PAGES[c_page];
    reject  = c_ill || (c_wr && c_wp);
    grant   = (state == IDLE) && (m0_sel || m1_sel);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant) state_nxt = reject ? RESP : BUSY;
      BUSY: if (f_ready) state_nxt = RESP;
      RESP: state_nxt = GAP;
      GAP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    f_sel    = (state == BUSY);
    f_wstrb  = f_sel ? req_wstrb : 4'h0;
    f_addr   = f_sel ? req_addr  : 15'h0;
    f_wdata  = f_sel ? req_wdata : 32'h0;
    m0_ready = (state == RESP) && !own;
    m1_ready = (state == RESP) && own;
    gnt      = 2'b00;
    if (state == BUSY || state == RESP) gnt = own ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= RR_INIT;
      own       <= 1'b0;
      req_wstrb <= 4'h0;
      req_addr  <= 15'h0;
      req_wdata <= 32'h0;
      m0_rdata  <= 32'h0;
      m1_rdata  <= 32'h0;
      err       <= 1'b0;
      err_src   <= 1'b0;
      err_page  <= 6'h0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        own       <= win;
        req_wstrb <= c_wstrb;
        req_addr  <= c_addr;
        req_wdata <= c_wdata;
        if (m0_sel && m1_sel) ptr <= ~win;
        if (reject) begin
          if (win) m1_rdata <= 32'h0;
          else     m0_rdata <= 32'h0;
        end
      end
      if (state == BUSY && f_ready) begin
        if (own) m1_rdata <= f_rdata;
        else     m0_rdata <= f_rdata;
      end
      // A rejection landing together with err_clr starts a fresh capture.
      if (grant && reject && (!err || err_clr)) begin
        err      <= 1'b1;
        err_src  <= win;
        err_page <= c_page;
      end else if (err_clr) begin
        err      <= 1'b0;
        err_src  <= 1'b0;
        err_page <= 6'h0;
      end
    end
  end

endmodule

// File: tb/tb_uflash_arb.sv
// Directed bench for uflash_arb: behavioural flash wrapper with programmable latency, hand-computed expectations.
module tb_uflash_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_sel, m1_sel;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [14:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        f_sel;
  logic [3:0]  f_wstrb;
  logic [14:0] f_addr;
  logic [31:0] f_wdata;
  logic        f_ready = 1'b0;
  logic [31:0] f_rdata = 32'h0;
  logic        err, err_src;
  logic [5:0]  err_page;
  logic        err_clr;
  logic [1:0]  gnt;

  int          errs = 0;
  int          checks = 0;
  int          fl_lat = 3;
  logic        fl_fixed = 1'b0;
  logic [31:0] fl_data = 32'h0;
  int          fl_cnt = 0;
  int          fsel_cycles = 0;
  int          lat;

  always #5 clk = ~clk;

  uflash_arb #(.WP_PAGES(38'h8), .RR_INIT(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_sel(m0_sel), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_sel(m1_sel), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .f_sel(f_sel), .f_wstrb(f_wstrb), .f_addr(f_addr), .f_wdata(f_wdata),
    .f_ready(f_ready), .f_rdata(f_rdata),
    .err(err), .err_src(err_src), .err_page(err_page), .err_clr(err_clr), .gnt(gnt)
  );

  // Flash wrapper: pulses f_ready after fl_lat cycles of f_sel; read data is a fixed word or derived from the address.
  always begin
    @(posedge clk);
    #1;
    f_ready = 1'b0;
    if (f_sel) begin
      fsel_cycles++;
      fl_cnt++;
      if (fl_cnt == fl_lat) begin
        f_ready = 1'b1;
        f_rdata = fl_fixed ? fl_data : {16'hD00D, 1'b0, f_addr};
      end
    end else begin
      fl_cnt = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int n);
    return (n != 0) ? m1_ready : m0_ready;
  endfunction

  function automatic logic [31:0] rdat(input int n);
    return (n != 0) ? m1_rdata : m0_rdata;
  endfunction

  task automatic set_req(input int n, input logic [3:0] ws, input logic [14:0] a, input logic [31:0] wd);
    if (n != 0) begin
      m1_sel = 1'b1; m1_wstrb = ws; m1_addr = a; m1_wdata = wd;
    end else begin
      m0_sel = 1'b1; m0_wstrb = ws; m0_addr = a; m0_wdata = wd;
    end
  endtask

  task automatic wait_rdy(input int n, input string tag, output int l);
    l = 0;
    while (!rdy(n) && l < 200) begin
      tick();
      l++;
    end
    if (!rdy(n)) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drop_gap(input int n, input string tag);
    if (n != 0) m1_sel = 1'b0;
    else        m0_sel = 1'b0;
    tick();
    chk({tag, "_gap_gnt"}, gnt, 2'b00);
    chk({tag, "_gap_fsel"}, f_sel, 1'b0);
    chk({tag, "_gap_rdy"}, rdy(n), 1'b0);
    tick();
    chk({tag, "_idle_gnt"}, gnt, 2'b00);
  endtask

  task automatic serve(input int n, input logic [31:0] exp_rd, input int exp_lat, input string tag);
    int l;
    int fs0;
    fs0 = fsel_cycles;
    tick();
    chk({tag, "_gnt"}, gnt, (n != 0) ? 2'b10 : 2'b01);
    chk({tag, "_fsel_at_grant"}, f_sel, exp_lat != 0);
    wait_rdy(n, tag, l);
    chk({tag, "_lat"}, l, exp_lat);
    chk({tag, "_rdata"}, rdat(n), exp_rd);
    chk({tag, "_other_rdy"}, rdy(1 - n), 1'b0);
    chk({tag, "_resp_gnt"}, gnt, (n != 0) ? 2'b10 : 2'b01);
    chk({tag, "_fsel_cycles"}, fsel_cycles - fs0, exp_lat);
    drop_gap(n, tag);
  endtask

  initial begin
    reset_n = 1'b0; err_clr = 1'b0;
    m0_sel = 1'b0; m0_wstrb = 4'h0; m0_addr = 15'h0; m0_wdata = 32'h0;
    m1_sel = 1'b0; m1_wstrb = 4'h0; m1_addr = 15'h0; m1_wdata = 32'h0;
    repeat (3) tick();
    chk("rst_fsel", f_sel, 1'b0);
    chk("rst_fbus", {f_wstrb, f_addr}, 32'h0);
    chk("rst_fwdata", f_wdata, 32'h0);
    chk("rst_ready", {m0_ready, m1_ready}, 2'b00);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    chk("rst_err", {err, err_src, err_page}, 8'h0);
    chk("rst_gnt", gnt, 2'b00);
    reset_n = 1'b1;
    tick();

    // Single m0 read, 20-cycle flash
    fl_fixed = 1'b1; fl_data = 32'hCAFEF00D; fl_lat = 20;
    set_req(0, 4'h0, 15'h0040, 32'h0);
    serve(0, 32'hCAFEF00D, 20, "t1");
    fl_fixed = 1'b0;

    // Simultaneous reads: round robin from RR_INIT=0, then alternated
    fl_lat = 3;
    set_req(0, 4'h0, 15'h0100, 32'h0);
    set_req(1, 4'h0, 15'h0200, 32'h0);
    serve(0, 32'hD00D0100, 3, "t2a");
    serve(1, 32'hD00D0200, 3, "t2b");
    chk("t2_m0_hold", m0_rdata, 32'hD00D0100);
    set_req(0, 4'h0, 15'h0104, 32'h0);
    set_req(1, 4'h0, 15'h0204, 32'h0);
    serve(1, 32'hD00D0204, 3, "t2c");
    serve(0, 32'hD00D0104, 3, "t2d");

    // Erase of protected page 3 by m1, then a read of the same word
    set_req(1, 4'h1, 15'h0600, 32'h0);
    serve(1, 32'h0, 0, "t3_erase");
    chk("t3_err", {err, err_src, err_page}, {1'b1, 1'b1, 6'd3});
    set_req(1, 4'h0, 15'h0600, 32'h0);
    serve(1, 32'hD00D0600, 3, "t3_read");
    chk("t3_err_kept", {err, err_src, err_page}, {1'b1, 1'b1, 6'd3});
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t3_clr", {err, err_src, err_page}, 8'h0);

    // Illegal strobe, then a nonexistent page; first error info sticks
    set_req(0, 4'h3, 15'h0A00, 32'h0);
    serve(0, 32'h0, 0, "t4_ill");
    chk("t4_err1", {err, err_src, err_page}, {1'b1, 1'b0, 6'd5});
    set_req(1, 4'hF, 15'h5000, 32'h1);
    serve(1, 32'h0, 0, "t4_p40");
    chk("t4_err2", {err, err_src, err_page}, {1'b1, 1'b0, 6'd5});
    set_req(1, 4'h1, 15'h0600, 32'h0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t4_clr_rej_rdy", m1_ready, 1'b1);
    chk("t4_clr_rej_err", {err, err_src, err_page}, {1'b1, 1'b1, 6'd3});
    drop_gap(1, "t4c");
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t4_clr", {err, err_src, err_page}, 8'h0);
    set_req(0, 4'hF, 15'h4A00, 32'hA5A5A5A5);
    serve(0, 32'hD00D4A00, 3, "t4_p37");
    chk("t4_p37_err", err, 1'b0);

    // Program on page 5; input changes and m1 request during BUSY
    fl_lat = 6;
    set_req(0, 4'hF, 15'h0A10, 32'h12345678);
    tick();
    chk("t5_gnt", gnt, 2'b01);
    chk("t5_fsel", f_sel, 1'b1);
    chk("t5_fwstrb", f_wstrb, 4'hF);
    chk("t5_faddr", f_addr, 15'h0A10);
    chk("t5_fwdata", f_wdata, 32'h12345678);
    m0_addr = 15'h7FFF; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    set_req(1, 4'h0, 15'h0020, 32'h0);
    tick();
    chk("t5_faddr_held", f_addr, 15'h0A10);
    chk("t5_fwdata_held", f_wdata, 32'h12345678);
    chk("t5_gnt_held", gnt, 2'b01);
    wait_rdy(0, "t5", lat);
    chk("t5_lat", lat, 5);
    chk("t5_m1_rdy", m1_ready, 1'b0);
    drop_gap(0, "t5");
    serve(1, 32'hD00D0020, 6, "t5_m1");

    // Reset pulse in the middle of BUSY
    fl_lat = 10;
    set_req(0, 4'h0, 15'h0080, 32'h0);
    tick();
    chk("t6_fsel", f_sel, 1'b1);
    tick(); tick();
    reset_n = 1'b0; m0_sel = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t6_fsel_rst", f_sel, 1'b0);
    chk("t6_gnt_rst", gnt, 2'b00);
    chk("t6_rdy_rst", {m0_ready, m1_ready}, 2'b00);
    chk("t6_m1_rdata_rst", m1_rdata, 32'h0);
    set_req(1, 4'h0, 15'h0100, 32'h0);
    serve(1, 32'hD00D0100, 10, "t6");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
